// File: rtl/exec_r2.sv
// Execute stage with its R2 output register: ALU, data-memory access, jumps and halt.
// Optional 1-cycle multiplier on opcode 09 when EXEC_MUL_EN is defined.
module exec_r2 #(
    parameter int D_SIZE = 32,
    parameter int A_SIZE = 10
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [6:0]        r1_opcode,
    input  logic [2:0]        r1_destination,
    input  logic [D_SIZE-1:0] r1_operand_a,
    input  logic [D_SIZE-1:0] r1_operand_b,
    input  logic [D_SIZE-1:0] data_in,
    output logic [A_SIZE-1:0] data_addr,
    output logic [D_SIZE-1:0] data_out,
    output logic              data_read_en,
    output logic              data_write_en,
    output logic              jump_en,
    output logic [D_SIZE-1:0] jump_target,
    output logic              r2_pc_halt,
    output logic              r2_pc_flush,
    output logic [6:0]        r2_opcode,
    output logic [2:0]        r2_destination,
    output logic [D_SIZE-1:0] r2_result,
    output logic              r2_write_en
);

    localparam logic [6:0] OP_ADD   = 7'h01;
    localparam logic [6:0] OP_SUB   = 7'h02;
    localparam logic [6:0] OP_AND   = 7'h03;
    localparam logic [6:0] OP_OR    = 7'h04;
    localparam logic [6:0] OP_XOR   = 7'h05;
    localparam logic [6:0] OP_SHL   = 7'h06;
    localparam logic [6:0] OP_SHR   = 7'h07;
    localparam logic [6:0] OP_LOADC = 7'h08;
`ifdef EXEC_MUL_EN
    localparam logic [6:0] OP_MUL   = 7'h09;
`endif
    localparam logic [6:0] OP_LOAD  = 7'h10;
    localparam logic [6:0] OP_STORE = 7'h11;
    localparam logic [6:0] OP_JMP   = 7'h20;
    localparam logic [6:0] OP_JMPZ  = 7'h21;
    localparam logic [6:0] OP_HALT  = 7'h7F;

    // Shift amounts are taken from the low SH_W bits; D_SIZE is assumed a power of two.
    localparam int SH_W = $clog2(D_SIZE);

    typedef enum logic [1:0] {
        S_EXEC,
        S_LOAD_WAIT,
        S_STOPPED
    } state_e;

    state_e              state_q, state_d;
    logic [2:0]          load_dest_q, load_dest_d;
    logic [6:0]          r2_opcode_q, r2_opcode_d;
    logic [2:0]          r2_destination_q, r2_destination_d;
    logic [D_SIZE-1:0]   r2_result_q, r2_result_d;
    logic                r2_write_en_q, r2_write_en_d;

    logic [D_SIZE-1:0]   alu_result;
    logic                alu_we;
    logic                shift_oob;
    logic                operand_b_zero;

    assign shift_oob      = |r1_operand_b[D_SIZE-1:SH_W];
    assign operand_b_zero = (r1_operand_b == '0);

    // ALU: result and write enable for every register-writing opcode.
    always_comb begin
        // NOTE: every variable written in a combinational block gets a default first,
        // so no path leaves it unassigned and no latch is inferred.
        alu_result = '0;
        alu_we     = 1'b0;
        case (r1_opcode)
            OP_ADD: begin
                alu_result = r1_operand_a + r1_operand_b;
                alu_we     = 1'b1;
            end
            OP_SUB: begin
                alu_result = r1_operand_a - r1_operand_b;
                alu_we     = 1'b1;
            end
            OP_AND: begin
                alu_result = r1_operand_a & r1_operand_b;
                alu_we     = 1'b1;
            end
            OP_OR: begin
                alu_result = r1_operand_a | r1_operand_b;
                alu_we     = 1'b1;
            end
            OP_XOR: begin
                alu_result = r1_operand_a ^ r1_operand_b;
                alu_we     = 1'b1;
            end
            OP_SHL: begin
                alu_result = shift_oob ? '0 : (r1_operand_a << r1_operand_b[SH_W-1:0]);
                alu_we     = 1'b1;
            end
            OP_SHR: begin
                alu_result = shift_oob ? '0 : (r1_operand_a >> r1_operand_b[SH_W-1:0]);
                alu_we     = 1'b1;
            end
            OP_LOADC: begin
                alu_result = r1_operand_b;
                alu_we     = 1'b1;
            end
`ifdef EXEC_MUL_EN
            OP_MUL: begin
                alu_result = r1_operand_a * r1_operand_b;
                alu_we     = 1'b1;
            end
`endif
            default: begin
                alu_result = '0;
                alu_we     = 1'b0;
            end
        endcase
    end

    // State register, R2 and the destination of an outstanding load.
    always_ff @(posedge clk) begin
        // NOTE: reset is synchronous; sequential state uses non-blocking assignments only.
        if (rst) begin
            state_q          <= S_EXEC;
            load_dest_q      <= '0;
            r2_opcode_q      <= '0;
            r2_destination_q <= '0;
            r2_result_q      <= '0;
            r2_write_en_q    <= 1'b0;
        end else begin
            state_q          <= state_d;
            load_dest_q      <= load_dest_d;
            r2_opcode_q      <= r2_opcode_d;
            r2_destination_q <= r2_destination_d;
            r2_result_q      <= r2_result_d;
            r2_write_en_q    <= r2_write_en_d;
        end
    end

    // Next-state logic.
    always_comb begin
        state_d     = state_q;
        load_dest_d = load_dest_q;
        case (state_q)
            S_EXEC: begin
                if (r1_opcode == OP_LOAD) begin
                    state_d     = S_LOAD_WAIT;
                    load_dest_d = r1_destination;
                end else if (r1_opcode == OP_HALT) begin
                    state_d = S_STOPPED;
                end
            end
            S_LOAD_WAIT: state_d = S_EXEC;
            S_STOPPED:   state_d = S_STOPPED;
            default:     state_d = S_EXEC;
        endcase
    end

    // Output logic: combinational handshakes and the value R2 loads next.
    always_comb begin
        data_addr        = '0;
        data_out         = '0;
        data_read_en     = 1'b0;
        data_write_en    = 1'b0;
        jump_en          = 1'b0;
        jump_target      = '0;
        r2_pc_halt       = 1'b0;
        r2_pc_flush      = 1'b0;
        r2_opcode_d      = '0;
        r2_destination_d = '0;
        r2_result_d      = '0;
        r2_write_en_d    = 1'b0;
        case (state_q)
            S_EXEC: begin
                data_addr   = r1_operand_a[A_SIZE-1:0];
                data_out    = r1_operand_b;
                jump_target = r1_operand_a;
                case (r1_opcode)
                    OP_LOAD: begin
                        // R1 is held while the read completes; R2 takes a bubble.
                        data_read_en = 1'b1;
                        r2_pc_halt   = 1'b1;
                    end
                    OP_HALT: begin
                        r2_pc_halt = 1'b1;
                    end
                    OP_STORE: begin
                        data_write_en    = 1'b1;
                        r2_opcode_d      = r1_opcode;
                        r2_destination_d = r1_destination;
                    end
                    OP_JMP, OP_JMPZ: begin
                        jump_en          = (r1_opcode == OP_JMP) || operand_b_zero;
                        r2_pc_flush      = jump_en;
                        r2_opcode_d      = r1_opcode;
                        r2_destination_d = r1_destination;
                    end
                    default: begin
                        r2_opcode_d      = r1_opcode;
                        r2_destination_d = r1_destination;
                        r2_result_d      = alu_result;
                        r2_write_en_d    = alu_we;
                    end
                endcase
            end
            S_LOAD_WAIT: begin
                r2_opcode_d      = OP_LOAD;
                r2_destination_d = load_dest_q;
                r2_result_d      = data_in;
                r2_write_en_d    = 1'b1;
            end
            S_STOPPED: begin
                r2_pc_halt = 1'b1;
            end
            default: begin
                r2_pc_halt = 1'b0;
            end
        endcase
    end

    assign r2_opcode      = r2_opcode_q;
    assign r2_destination = r2_destination_q;
    assign r2_result      = r2_result_q;
    assign r2_write_en    = r2_write_en_q;

endmodule

// File: tb/tb_exec_r2.sv
// Self-checking bench for exec_r2: a cycle-level reference model checked every cycle,
// plus directed vectors with hand-computed expectations.
module tb_exec_r2;

    localparam logic [6:0] OP_NOP   = 7'h00;
    localparam logic [6:0] OP_ADD   = 7'h01;
    localparam logic [6:0] OP_SUB   = 7'h02;
    localparam logic [6:0] OP_AND   = 7'h03;
    localparam logic [6:0] OP_OR    = 7'h04;
    localparam logic [6:0] OP_XOR   = 7'h05;
    localparam logic [6:0] OP_SHL   = 7'h06;
    localparam logic [6:0] OP_SHR   = 7'h07;
    localparam logic [6:0] OP_LOADC = 7'h08;
    localparam logic [6:0] OP_MUL   = 7'h09;
    localparam logic [6:0] OP_LOAD  = 7'h10;
    localparam logic [6:0] OP_STORE = 7'h11;
    localparam logic [6:0] OP_JMP   = 7'h20;
    localparam logic [6:0] OP_JMPZ  = 7'h21;
    localparam logic [6:0] OP_HALT  = 7'h7F;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [6:0]  r1_opcode = '0;
    logic [2:0]  r1_destination = '0;
    logic [31:0] r1_operand_a = '0;
    logic [31:0] r1_operand_b = '0;
    logic [31:0] data_in = '0;
    logic [9:0]  data_addr;
    logic [31:0] data_out;
    logic        data_read_en;
    logic        data_write_en;
    logic        jump_en;
    logic [31:0] jump_target;
    logic        r2_pc_halt;
    logic        r2_pc_flush;
    logic [6:0]  r2_opcode;
    logic [2:0]  r2_destination;
    logic [31:0] r2_result;
    logic        r2_write_en;

    int n_checks = 0;
    int n_fail   = 0;

    exec_r2 #(.D_SIZE(32), .A_SIZE(10)) dut (
        .clk            (clk),
        .rst            (rst),
        .r1_opcode      (r1_opcode),
        .r1_destination (r1_destination),
        .r1_operand_a   (r1_operand_a),
        .r1_operand_b   (r1_operand_b),
        .data_in        (data_in),
        .data_addr      (data_addr),
        .data_out       (data_out),
        .data_read_en   (data_read_en),
        .data_write_en  (data_write_en),
        .jump_en        (jump_en),
        .jump_target    (jump_target),
        .r2_pc_halt     (r2_pc_halt),
        .r2_pc_flush    (r2_pc_flush),
        .r2_opcode      (r2_opcode),
        .r2_destination (r2_destination),
        .r2_result      (r2_result),
        .r2_write_en    (r2_write_en)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference result of a register-writing instruction, straight from the opcode table.
    function automatic void ref_alu(input logic [6:0] op, input logic [31:0] a, input logic [31:0] b,
                                    output logic [31:0] res, output logic we);
        we = 1'b1;
        case (op)
            OP_ADD:   res = a + b;
            OP_SUB:   res = a - b;
            OP_AND:   res = a & b;
            OP_OR:    res = a | b;
            OP_XOR:   res = a ^ b;
            OP_SHL:   res = (b >= 32) ? 32'd0 : a << b;
            OP_SHR:   res = (b >= 32) ? 32'd0 : a >> b;
            OP_LOADC: res = b;
`ifdef EXEC_MUL_EN
            OP_MUL:   res = a * b;
`endif
            default: begin
                res = 32'd0;
                we  = 1'b0;
            end
        endcase
    endfunction

    // Model state: what R2 must hold now, plus whether a load or a halt is outstanding.
    logic [6:0]  m_op   = '0;
    logic [2:0]  m_dest = '0;
    logic [31:0] m_res  = '0;
    logic        m_we   = 1'b0;
    bit          m_waiting = 1'b0;
    bit          m_stopped = 1'b0;
    logic [2:0]  m_wait_dest = '0;

    initial begin
        logic [31:0] e_res;
        logic        e_we;
        logic        is_jump;
        forever begin
            @(negedge clk);
            if (rst) begin
                m_op = '0; m_dest = '0; m_res = '0; m_we = 1'b0;
                m_waiting = 1'b0; m_stopped = 1'b0;
            end else begin
                check("m_r2_opcode", {25'd0, r2_opcode}, {25'd0, m_op});
                check("m_r2_dest", {29'd0, r2_destination}, {29'd0, m_dest});
                check("m_r2_result", r2_result, m_res);
                check("m_r2_we", {31'd0, r2_write_en}, {31'd0, m_we});
                if (m_stopped || m_waiting) begin
                    check("m_halt", {31'd0, r2_pc_halt}, {31'd0, m_stopped});
                    check("m_flush", {31'd0, r2_pc_flush}, 32'd0);
                    check("m_read_en", {31'd0, data_read_en}, 32'd0);
                    check("m_write_en", {31'd0, data_write_en}, 32'd0);
                    check("m_jump_en", {31'd0, jump_en}, 32'd0);
                    check("m_jump_target", jump_target, 32'd0);
                    check("m_data_addr", {22'd0, data_addr}, 32'd0);
                    check("m_data_out", data_out, 32'd0);
                end else begin
                    is_jump = (r1_opcode == OP_JMP) || (r1_opcode == OP_JMPZ && r1_operand_b == 0);
                    check("m_halt", {31'd0, r2_pc_halt},
                          {31'd0, (r1_opcode == OP_LOAD) || (r1_opcode == OP_HALT)});
                    check("m_flush", {31'd0, r2_pc_flush}, {31'd0, is_jump});
                    check("m_read_en", {31'd0, data_read_en}, {31'd0, r1_opcode == OP_LOAD});
                    check("m_write_en", {31'd0, data_write_en}, {31'd0, r1_opcode == OP_STORE});
                    check("m_jump_en", {31'd0, jump_en}, {31'd0, is_jump});
                    check("m_jump_target", jump_target, r1_operand_a);
                    check("m_data_addr", {22'd0, data_addr}, {22'd0, r1_operand_a[9:0]});
                    check("m_data_out", data_out, r1_operand_b);
                end
                // Advance the model to what R2 must hold after the coming edge.
                if (m_stopped) begin
                    m_op = '0; m_dest = '0; m_res = '0; m_we = 1'b0;
                end else if (m_waiting) begin
                    m_op = OP_LOAD; m_dest = m_wait_dest; m_res = data_in; m_we = 1'b1;
                    m_waiting = 1'b0;
                end else if (r1_opcode == OP_LOAD) begin
                    m_op = '0; m_dest = '0; m_res = '0; m_we = 1'b0;
                    m_waiting = 1'b1; m_wait_dest = r1_destination;
                end else if (r1_opcode == OP_HALT) begin
                    m_op = '0; m_dest = '0; m_res = '0; m_we = 1'b0;
                    m_stopped = 1'b1;
                end else begin
                    ref_alu(r1_opcode, r1_operand_a, r1_operand_b, e_res, e_we);
                    m_op = r1_opcode; m_dest = r1_destination; m_res = e_res; m_we = e_we;
                end
            end
        end
    end

    task automatic step(input logic [6:0] op, input logic [2:0] dest,
                        input logic [31:0] a, input logic [31:0] b, input logic [31:0] din);
        @(posedge clk);
        #1;
        r1_opcode = op; r1_destination = dest; r1_operand_a = a; r1_operand_b = b; data_in = din;
        @(negedge clk);
    endtask

    task automatic pulse_reset(input logic [31:0] din);
        @(posedge clk);
        #1;
        rst = 1'b1;
        r1_opcode = OP_NOP; r1_destination = '0; r1_operand_a = '0; r1_operand_b = '0; data_in = din;
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        check("rst_r2_opcode", {25'd0, r2_opcode}, 32'd0);
        check("rst_r2_result", r2_result, 32'd0);
        check("rst_r2_we", {31'd0, r2_write_en}, 32'd0);
        check("rst_halt", {31'd0, r2_pc_halt}, 32'd0);
        check("rst_flush", {31'd0, r2_pc_flush}, 32'd0);

        step(OP_ADD, 3'd3, 32'd7, 32'd5, 32'd0);
        step(OP_SUB, 3'd1, 32'd0, 32'd1, 32'd0);
        check("add_result", r2_result, 32'd12);
        check("add_dest", {29'd0, r2_destination}, 32'd3);
        check("add_we", {31'd0, r2_write_en}, 32'd1);
        step(OP_SHL, 3'd2, 32'd1, 32'd35, 32'd0);
        check("sub_result", r2_result, 32'hFFFF_FFFF);
        step(OP_SHR, 3'd4, 32'h8000_0000, 32'd31, 32'd0);
        check("shl_oob_result", r2_result, 32'd0);
        check("shl_oob_we", {31'd0, r2_write_en}, 32'd1);
        step(OP_AND, 3'd5, 32'hF0F0_1234, 32'h0FF0_FF00, 32'd0);
        check("shr_result", r2_result, 32'd1);
        step(OP_OR,    3'd6, 32'h0000_00F0, 32'h0000_000F, 32'd0);
        step(OP_XOR,   3'd7, 32'hFFFF_0000, 32'h0F0F_0F0F, 32'd0);
        step(OP_LOADC, 3'd1, 32'd99, 32'h0000_ABCD, 32'd0);
        step(7'h33,    3'd2, 32'd1, 32'd2, 32'd0);
        check("loadc_result", r2_result, 32'h0000_ABCD);

        // LOAD: issue cycle, wait cycle (R1 still shows the LOAD), write-back.
        step(OP_LOAD, 3'd5, 32'd4, 32'd0, 32'd0);
        check("unknown_we", {31'd0, r2_write_en}, 32'd0);
        check("load_read_en", {31'd0, data_read_en}, 32'd1);
        check("load_halt", {31'd0, r2_pc_halt}, 32'd1);
        check("load_addr", {22'd0, data_addr}, 32'd4);
        step(OP_LOAD, 3'd5, 32'd4, 32'd0, 32'h0000_CAFE);
        check("load_wait_halt", {31'd0, r2_pc_halt}, 32'd0);
        check("load_wait_read_en", {31'd0, data_read_en}, 32'd0);
        check("load_bubble_we", {31'd0, r2_write_en}, 32'd0);
        step(OP_STORE, 3'd0, 32'd9, 32'd42, 32'd0);
        check("load_result", r2_result, 32'h0000_CAFE);
        check("load_we", {31'd0, r2_write_en}, 32'd1);
        check("load_dest", {29'd0, r2_destination}, 32'd5);
        check("store_write_en", {31'd0, data_write_en}, 32'd1);
        check("store_addr", {22'd0, data_addr}, 32'd9);
        check("store_data", data_out, 32'd42);

        step(OP_JMPZ, 3'd0, 32'd100, 32'd0, 32'd0);
        check("store_r2_we", {31'd0, r2_write_en}, 32'd0);
        check("jmpz_taken_jump", {31'd0, jump_en}, 32'd1);
        check("jmpz_taken_target", jump_target, 32'd100);
        check("jmpz_taken_flush", {31'd0, r2_pc_flush}, 32'd1);
        step(OP_JMPZ, 3'd0, 32'd100, 32'd3, 32'd0);
        check("jmpz_not_jump", {31'd0, jump_en}, 32'd0);
        check("jmpz_not_flush", {31'd0, r2_pc_flush}, 32'd0);
        step(OP_JMP, 3'd0, 32'd55, 32'd7, 32'd0);
        check("jmp_jump", {31'd0, jump_en}, 32'd1);
        step(OP_MUL, 3'd3, 32'd6, 32'd7, 32'd0);
        step(OP_NOP, 3'd0, 32'd0, 32'd0, 32'd0);
`ifdef EXEC_MUL_EN
        check("mul_result", r2_result, 32'd42);
        check("mul_we", {31'd0, r2_write_en}, 32'd1);
`else
        check("mul_result", r2_result, 32'd0);
        check("mul_we", {31'd0, r2_write_en}, 32'd0);
`endif

        // HALT holds for good; R1 keeps presenting an ADD that must be ignored.
        step(OP_HALT, 3'd0, 32'd0, 32'd0, 32'd0);
        check("halt_issue", {31'd0, r2_pc_halt}, 32'd1);
        for (int i = 0; i < 22; i++) begin
            step(OP_ADD, 3'd1, 32'd1, 32'd1, 32'd0);
            check("halt_held", {31'd0, r2_pc_halt}, 32'd1);
            check("halt_r2_we", {31'd0, r2_write_en}, 32'd0);
        end
        pulse_reset(32'd0);
        check("halt_rst_halt", {31'd0, r2_pc_halt}, 32'd0);
        step(OP_ADD, 3'd1, 32'd2, 32'd3, 32'd0);
        step(OP_NOP, 3'd0, 32'd0, 32'd0, 32'd0);
        check("post_halt_add", r2_result, 32'd5);
        check("post_halt_we", {31'd0, r2_write_en}, 32'd1);

        // Reset while the load is outstanding discards the returned data.
        step(OP_LOAD, 3'd2, 32'd8, 32'd0, 32'd0);
        pulse_reset(32'h0000_BEEF);
        check("load_rst_we", {31'd0, r2_write_en}, 32'd0);
        check("load_rst_result", r2_result, 32'd0);
        step(OP_ADD, 3'd2, 32'd10, 32'd20, 32'd0);
        step(OP_NOP, 3'd0, 32'd0, 32'd0, 32'd0);
        check("post_load_rst_add", r2_result, 32'd30);
        check("post_load_rst_we", {31'd0, r2_write_en}, 32'd1);
        step(OP_NOP, 3'd0, 32'd0, 32'd0, 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
